// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the memory-stage SRAM controller.
package arm_mem_pkg;

  localparam int SRAM_AW           = 18;
  localparam int SRAM_DW           = 16;
  localparam int DEFAULT_BASE_ADDR = 1024;

  // Access sequencing: request accepted in IDLE, low half, high half,
  // then a single release cycle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_e;

  // 32-bit word index relative to the SRAM base. Bits above 16 are
  // deliberately dropped and the byte offset within the word is ignored.
  function automatic logic [SRAM_AW-2:0] word_index(input logic [31:0] addr,
                                                    input logic [31:0] base);
    return (SRAM_AW-1)'((addr - base) >> 2);
  endfunction

endpackage

// File: rtl/sram_controller.sv
// Memory-stage responder: splits a 32-bit load/store into two 16-bit SRAM
// accesses and holds ready low to freeze the pipeline meanwhile.
module sram_controller
  import arm_mem_pkg::*;
#(
  parameter int BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int WAIT      = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        writeData,
  output logic [31:0]        readData,
  output logic               ready,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  inout  wire  [SRAM_DW-1:0] SRAM_DQ,
  output logic               SRAM_WE_N
);

  // Terminal count of the per-half wait counter.
  localparam logic [2:0] LAST_CNT = 3'(WAIT - 1);

  state_e             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [SRAM_AW-2:0] word_q, word_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               is_wr_q, is_wr_d;

  logic               half;
  logic               drive;

  // Next-state logic: latch the request, step through both halves, release.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    is_wr_d = is_wr_q;
    case (state_q)
      IDLE: begin
        if (rd_en || wr_en) begin
          // A simultaneous read and write request is served as a write.
          word_d  = word_index(address, 32'(BASE_ADDR));
          wdata_d = writeData;
          is_wr_d = wr_en;
          cnt_d   = 3'd0;
          state_d = LO;
        end
      end
      LO: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = 3'd0;
          state_d = HI;
          if (!is_wr_q) rdata_d[15:0] = SRAM_DQ;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      HI: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = 3'd0;
          state_d = DONE;
          if (!is_wr_q) rdata_d[31:16] = SRAM_DQ;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      // Requests still visible here belong to the access just finished.
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control and address/read-data registers; reset abandons any access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      word_q  <= '0;
      rdata_q <= '0;
      is_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
      is_wr_q <= is_wr_d;
    end
  end

  // Store data latch; only meaningful while a write is in flight.
  always_ff @(posedge clk) begin
    wdata_q <= wdata_d;
  end

  // SRAM-side decode from registered state only.
  always_comb begin
    half      = (state_q == HI);
    drive     = is_wr_q && ((state_q == LO) || (state_q == HI));
    SRAM_ADDR = {word_q, half};
    SRAM_WE_N = ~drive;
    readData  = rdata_q;
  end

  // Pipeline handshake: a new request freezes at once; DONE releases.
  always_comb begin
    case (state_q)
      IDLE:    ready = ~(rd_en | wr_en);
      DONE:    ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  assign SRAM_DQ = drive ? (half ? wdata_q[31:16] : wdata_q[15:0]) : {SRAM_DW{1'bz}};

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller with a behavioural SRAM and a
// word-level reference memory.
module tb_sram_controller;

  localparam int W    = 2;
  localparam int BASE = 1024;
  localparam int FREEZE = 2 * W + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en, wr_en;
  logic [31:0] address, writeData;
  wire  [31:0] readData;
  wire         ready;
  wire  [17:0] SRAM_ADDR;
  wire  [15:0] sram_dq;
  wire         SRAM_WE_N;

  sram_controller #(.BASE_ADDR(BASE), .WAIT(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_en     (rd_en),
    .wr_en     (wr_en),
    .address   (address),
    .writeData (writeData),
    .readData  (readData),
    .ready     (ready),
    .SRAM_ADDR (SRAM_ADDR),
    .SRAM_DQ   (sram_dq),
    .SRAM_WE_N (SRAM_WE_N)
  );

  always #5 clk = ~clk;

  // Behavioural 256K x 16 SRAM: combinational read, write on the clock edge.
  logic [15:0] sram [0:262143];
  assign sram_dq = SRAM_WE_N ? sram[SRAM_ADDR] : 16'bz;
  always @(posedge clk) begin
    if (!SRAM_WE_N) sram[SRAM_ADDR] <= sram_dq;
  end

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Reference: 32-bit words by index, plus the expected load-data register.
  logic [31:0] ref_mem [int];
  logic [31:0] ref_rd = 32'h0;

  // Observations from the most recent access.
  int          obs_freeze;
  logic [17:0] obs_addr_lo, obs_addr_hi;
  logic        obs_we_lo, obs_we_hi;
  logic [31:0] obs_rd_done;

  function automatic int widx(input logic [31:0] a);
    return int'(((a - 32'(BASE)) >> 2) & 32'h1FFFF);
  endfunction

  function automatic logic [31:0] ref_read(input int i);
    return ref_mem.exists(i) ? ref_mem[i] : 32'h0;
  endfunction

  // Drives one access and records what the DUT did; updates the model.
  // no_wait: drive in the current cycle (used from a DONE cycle).
  task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input bit scramble,
                        input bit hold, input bit no_wait);
    int c;
    c = 0;
    if (!no_wait) @(negedge clk);
    rd_en = rd; wr_en = wr; address = a; writeData = d;
    if (no_wait) @(negedge clk);
    #1;
    obs_addr_lo = '1; obs_addr_hi = '1; obs_we_lo = 1'bx; obs_we_hi = 1'bx;
    while (!ready && c < 50) begin
      if (c == 1) begin
        obs_addr_lo = SRAM_ADDR;
        obs_we_lo   = SRAM_WE_N;
        if (scramble) begin address = 32'h0; writeData = 32'h0; end
      end
      if (c == 2 * W) begin
        obs_addr_hi = SRAM_ADDR;
        obs_we_hi   = SRAM_WE_N;
      end
      @(negedge clk); #1;
      c++;
    end
    obs_freeze  = c;
    obs_rd_done = readData;
    if (!hold) begin rd_en = 1'b0; wr_en = 1'b0; end
    if (wr) ref_mem[widx(a)] = d;
    else if (rd) ref_rd = ref_read(widx(a));
  endtask

  task automatic test_reset();
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = '0; writeData = '0;
    @(negedge clk); @(negedge clk); #1;
    chk_cnt++; if (ready !== 1'b1) $display("FAIL reset_ready got=%b want=1", ready); else pass_cnt++;
    chk_cnt++; if (readData !== 32'h0) $display("FAIL reset_rdata got=%h want=0", readData); else pass_cnt++;
    chk_cnt++; if (SRAM_ADDR !== 18'h0) $display("FAIL reset_addr got=%h want=0", SRAM_ADDR); else pass_cnt++;
    chk_cnt++; if (SRAM_WE_N !== 1'b1) $display("FAIL reset_we_n got=%b want=1", SRAM_WE_N); else pass_cnt++;
    rd_en = 1'b1; #1;
    chk_cnt++; if (ready !== 1'b0) $display("FAIL reset_ready_req got=%b want=0", ready); else pass_cnt++;
    rd_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_store_load();
    access(0, 1, 32'd1024, 32'hDEADBEEF, 0, 0, 0);
    chk_cnt++; if (obs_freeze !== FREEZE) $display("FAIL store_freeze got=%0d want=%0d", obs_freeze, FREEZE); else pass_cnt++;
    chk_cnt++; if (obs_addr_lo !== 18'd0 || obs_addr_hi !== 18'd1) $display("FAIL store_addr got=%0d,%0d want=0,1", obs_addr_lo, obs_addr_hi); else pass_cnt++;
    chk_cnt++; if (obs_we_lo !== 1'b0 || obs_we_hi !== 1'b0) $display("FAIL store_we_n got=%b,%b want=0,0", obs_we_lo, obs_we_hi); else pass_cnt++;
    chk_cnt++; if (sram[0] !== 16'hBEEF || sram[1] !== 16'hDEAD) $display("FAIL store_data got=%h,%h want=beef,dead", sram[0], sram[1]); else pass_cnt++;
    access(1, 0, 32'd1024, 32'h0, 0, 0, 0);
    chk_cnt++; if (obs_freeze !== FREEZE) $display("FAIL load_freeze got=%0d want=%0d", obs_freeze, FREEZE); else pass_cnt++;
    chk_cnt++; if (obs_we_lo !== 1'b1 || obs_we_hi !== 1'b1) $display("FAIL load_we_n got=%b,%b want=1,1", obs_we_lo, obs_we_hi); else pass_cnt++;
    chk_cnt++; if (obs_rd_done !== 32'hDEADBEEF) $display("FAIL load_data got=%h want=deadbeef", obs_rd_done); else pass_cnt++;
  endtask

  task automatic test_address_map();
    logic [31:0] v;
    v = $urandom;
    access(0, 1, 32'd1032, v, 0, 0, 0);
    access(1, 0, 32'd1032, 32'h0, 0, 0, 0);
    chk_cnt++; if (obs_addr_lo !== 18'd4 || obs_addr_hi !== 18'd5) $display("FAIL map_1032 got=%0d,%0d want=4,5", obs_addr_lo, obs_addr_hi); else pass_cnt++;
    chk_cnt++; if (obs_rd_done !== v) $display("FAIL map_1032_data got=%h want=%h", obs_rd_done, v); else pass_cnt++;
    access(1, 0, 32'd1035, 32'h0, 0, 0, 0);
    chk_cnt++; if (obs_addr_lo !== 18'd4 || obs_addr_hi !== 18'd5) $display("FAIL map_1035 got=%0d,%0d want=4,5", obs_addr_lo, obs_addr_hi); else pass_cnt++;
    chk_cnt++; if (obs_rd_done !== v) $display("FAIL map_1035_data got=%h want=%h", obs_rd_done, v); else pass_cnt++;
    // Index bit 17 falls off the top: aliases onto word 2.
    access(1, 0, 32'd1024 + (32'd1 << 19) + 32'd8, 32'h0, 0, 0, 0);
    chk_cnt++; if (obs_addr_lo !== 18'd4 || obs_addr_hi !== 18'd5) $display("FAIL map_wrap got=%0d,%0d want=4,5", obs_addr_lo, obs_addr_hi); else pass_cnt++;
    chk_cnt++; if (obs_rd_done !== v) $display("FAIL map_wrap_data got=%h want=%h", obs_rd_done, v); else pass_cnt++;
  endtask

  task automatic test_freeze_stability();
    access(0, 1, 32'd1040, 32'h12345678, 1, 0, 0);
    chk_cnt++; if (sram[8] !== 16'h5678 || sram[9] !== 16'h1234) $display("FAIL stable_sram got=%h,%h want=5678,1234", sram[8], sram[9]); else pass_cnt++;
    access(1, 0, 32'd1040, 32'h0, 0, 0, 0);
    chk_cnt++; if (obs_rd_done !== 32'h12345678) $display("FAIL stable_load got=%h want=12345678", obs_rd_done); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d0, d1;
    d0 = $urandom; d1 = $urandom;
    access(0, 1, 32'd1024, d0, 0, 1, 0);
    chk_cnt++; if (obs_freeze !== FREEZE) $display("FAIL b2b_first got=%0d want=%0d", obs_freeze, FREEZE); else pass_cnt++;
    // Still in the DONE cycle with wr_en held: present the next store.
    access(0, 1, 32'd1028, d1, 0, 0, 1);
    chk_cnt++; if (obs_freeze !== FREEZE) $display("FAIL b2b_second got=%0d want=%0d", obs_freeze, FREEZE); else pass_cnt++;
    chk_cnt++; if ({sram[1], sram[0]} !== ref_read(0)) $display("FAIL b2b_word0 got=%h want=%h", {sram[1], sram[0]}, ref_read(0)); else pass_cnt++;
    chk_cnt++; if ({sram[3], sram[2]} !== ref_read(1)) $display("FAIL b2b_word1 got=%h want=%h", {sram[3], sram[2]}, ref_read(1)); else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    logic [31:0] v;
    v = $urandom;
    access(1, 1, 32'd1060, v, 0, 0, 0);
    chk_cnt++; if (obs_we_lo !== 1'b0) $display("FAIL simul_we_n got=%b want=0", obs_we_lo); else pass_cnt++;
    chk_cnt++; if (obs_rd_done !== ref_rd) $display("FAIL simul_rdata got=%h want=%h", obs_rd_done, ref_rd); else pass_cnt++;
    chk_cnt++; if ({sram[19], sram[18]} !== v) $display("FAIL simul_word got=%h want=%h", {sram[19], sram[18]}, v); else pass_cnt++;
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] old_v, new_v, expv;
    old_v = $urandom; new_v = $urandom;
    access(0, 1, 32'd1048, old_v, 0, 0, 0);
    @(negedge clk);
    wr_en = 1'b1; address = 32'd1048; writeData = new_v;   // IDLE, request seen
    @(negedge clk);                                         // first LO cycle
    @(negedge clk);                                         // second LO cycle
    rst = 1'b1; wr_en = 1'b0;
    @(negedge clk); #1;
    chk_cnt++; if (SRAM_WE_N !== 1'b1) $display("FAIL rstmid_we_n got=%b want=1", SRAM_WE_N); else pass_cnt++;
    chk_cnt++; if (ready !== 1'b1) $display("FAIL rstmid_idle got=%b want=1", ready); else pass_cnt++;
    chk_cnt++; if (readData !== 32'h0) $display("FAIL rstmid_rdata got=%h want=0", readData); else pass_cnt++;
    rst = 1'b0;
    // Low half was written before reset took effect; high half kept.
    ref_mem[widx(32'd1048)] = {old_v[31:16], new_v[15:0]};
    ref_rd = 32'h0;
    expv = {old_v[31:16], new_v[15:0]};
    access(1, 0, 32'd1048, 32'h0, 0, 0, 0);
    chk_cnt++; if (obs_freeze !== FREEZE) $display("FAIL rstmid_load_freeze got=%0d want=%0d", obs_freeze, FREEZE); else pass_cnt++;
    chk_cnt++; if (obs_rd_done !== expv) $display("FAIL rstmid_load got=%h want=%h", obs_rd_done, expv); else pass_cnt++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 32; i++) access(0, 1, 32'(BASE + 4 * i), $urandom, 0, 0, 0);
    for (int n = 0; n < 24; n++) begin
      int          idx;
      bit          wr;
      logic [31:0] a;
      idx = $urandom_range(0, 31);
      wr  = $urandom_range(0, 1);
      a   = 32'(BASE + 4 * idx) + 32'($urandom_range(0, 3));
      access(~wr, wr, a, $urandom, 0, 0, 0);
      chk_cnt++; if (obs_freeze !== FREEZE) $display("FAIL rand_freeze[%0d] got=%0d want=%0d", n, obs_freeze, FREEZE); else pass_cnt++;
      chk_cnt++; if (obs_addr_lo !== 18'(2 * idx) || obs_addr_hi !== 18'(2 * idx + 1)) $display("FAIL rand_addr[%0d] got=%0d,%0d want=%0d,%0d", n, obs_addr_lo, obs_addr_hi, 2 * idx, 2 * idx + 1); else pass_cnt++;
      chk_cnt++; if (obs_rd_done !== ref_rd) $display("FAIL rand_rdata[%0d] got=%h want=%h", n, obs_rd_done, ref_rd); else pass_cnt++;
      chk_cnt++; if ({sram[2 * idx + 1], sram[2 * idx]} !== ref_read(idx)) $display("FAIL rand_mem[%0d] got=%h want=%h", n, {sram[2 * idx + 1], sram[2 * idx]}, ref_read(idx)); else pass_cnt++;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_store_load();
    test_address_map();
    test_freeze_stability();
    test_back_to_back();
    test_simultaneous();
    test_reset_mid_write();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
